// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//
// Writer side of the register file. Merges single-cycle ALU results and
// long-latency (load / mul-div) results onto the single regfile write port.
// Long-latency results are buffered in a small FIFO. A scoreboard tracks
// destination registers that still have a long-latency result outstanding.
// The decode stage is stalled on source hazards (comb) and, when the ALU has
// starved the FIFO for too long, for one cycle so the FIFO head can drain.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   alu_valid/rd/data    ALU result, always accepted
//   lu_valid/rd/data     long-latency result offered to the FIFO
//   lu_ready             FIFO has room (from registered occupancy)
//   issue_valid/rd       decode issues a long-latency op writing issue_rd
//   rs1, rs2             decode source registers for the hazard check
//   hazard               comb: a source register has a pending write
//   pipe_stall           registered one-cycle forced-drain stall
//   err                  sticky: an ALU result was dropped during pipe_stall
//   w_enb, rd, w_data    registered regfile write port
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
   parameter int XLEN       = 32,
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            alu_valid,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            lu_valid,
   output logic            lu_ready,
   input  logic [4:0]      lu_rd,
   input  logic [XLEN-1:0] lu_data,
   input  logic            issue_valid,
   input  logic [4:0]      issue_rd,
   input  logic [4:0]      rs1,
   input  logic [4:0]      rs2,
   output logic            hazard,
   output logic            pipe_stall,
   output logic            err,
   output logic            w_enb,
   output logic [4:0]      rd,
   output logic [XLEN-1:0] w_data
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam int EW = XLEN + 5;

   localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
   localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [EW-1:0]   fifo_mem [DEPTH];
   logic [PW-1:0]   head_reg, head_next;
   logic [PW-1:0]   tail_reg, tail_next;
   logic [CW-1:0]   count_reg, count_next;
   logic [SW-1:0]   starve_cnt_reg, starve_cnt_next;
   logic            pipe_stall_reg, pipe_stall_next;
   logic            err_reg, err_next;
   logic [31:0]     pending_reg, pending_next;
   logic            w_enb_reg, w_enb_next;
   logic [4:0]      rd_reg, rd_next;
   logic [XLEN-1:0] w_data_reg, w_data_next;

   // ---------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------
   logic            fifo_ne;
   logic            push;
   logic            drain;
   logic            pop;
   logic            alu_win;
   logic [EW-1:0]   head_entry;
   logic [4:0]      head_rd;
   logic [XLEN-1:0] head_data;

   assign head_entry = fifo_mem[head_reg];
   assign head_rd    = head_entry[EW-1:XLEN];
   assign head_data  = head_entry[XLEN-1:0];

   // Occupancy is registered, so an entry pushed this cycle is never
   // eligible for arbitration until the following cycle.
   assign fifo_ne  = (count_reg != '0);
   assign lu_ready = (count_reg < DEPTH_C);
   assign push     = lu_valid & lu_ready;

   // Forced drain overrides the ALU; otherwise the ALU has priority.
   assign drain    = pipe_stall_reg & fifo_ne;
   assign pop      = drain | (~alu_valid & fifo_ne);
   assign alu_win  = alu_valid & ~drain;

   // ---------------------------------------------------------------------
   // FIFO pointers and occupancy
   // ---------------------------------------------------------------------
   always_comb begin
      head_next  = head_reg;
      tail_next  = tail_reg;
      count_next = count_reg;
      if (push) begin
         tail_next = tail_reg + 1'b1;
      end
      if (pop) begin
         head_next = head_reg + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   // Storage needs no reset: occupancy decides which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[tail_reg] <= {lu_rd, lu_data};
      end
   end

   // ---------------------------------------------------------------------
   // Starvation tracking and forced-drain stall
   // ---------------------------------------------------------------------
   always_comb begin
      starve_cnt_next = '0;
      pipe_stall_next = 1'b0;
      if (alu_win && fifo_ne) begin
         if (starve_cnt_reg == STARVE_LAST) begin
            // This win would reach the limit: stall once and start over.
            pipe_stall_next = 1'b1;
            starve_cnt_next = '0;
         end else begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
         end
      end
   end

   // An ALU result presented while the FIFO is being force-drained is lost.
   assign err_next = err_reg | (drain & alu_valid);

   // ---------------------------------------------------------------------
   // Write port: rd/w_data hold while no write is committed
   // ---------------------------------------------------------------------
   always_comb begin
      w_enb_next  = 1'b0;
      rd_next     = rd_reg;
      w_data_next = w_data_reg;
      if (pop) begin
         // A popped x0 entry is consumed but never written.
         if (head_rd != 5'd0) begin
            w_enb_next  = 1'b1;
            rd_next     = head_rd;
            w_data_next = head_data;
         end
      end else if (alu_win) begin
         if (alu_rd != 5'd0) begin
            w_enb_next  = 1'b1;
            rd_next     = alu_rd;
            w_data_next = alu_data;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Scoreboard: one bit per architectural register, x0 never pending.
   // A new issue in the same cycle as the retiring pop keeps the bit set.
   // ---------------------------------------------------------------------
   assign pending_next[0] = 1'b0;

   genvar gi;
   generate
      for (gi = 1; gi < 32; gi = gi + 1) begin : g_pending
         logic set_bit;
         logic clr_bit;
         assign set_bit = issue_valid & (issue_rd == 5'(gi));
         assign clr_bit = pop & (head_rd == 5'(gi));
         assign pending_next[gi] = set_bit | (pending_reg[gi] & ~clr_bit);
      end
   endgenerate

   assign hazard = pending_reg[rs1] | pending_reg[rs2];

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_reg       <= '0;
         tail_reg       <= '0;
         count_reg      <= '0;
         starve_cnt_reg <= '0;
         pipe_stall_reg <= 1'b0;
         err_reg        <= 1'b0;
         pending_reg    <= '0;
         w_enb_reg      <= 1'b0;
         rd_reg         <= '0;
         w_data_reg     <= '0;
      end else begin
         head_reg       <= head_next;
         tail_reg       <= tail_next;
         count_reg      <= count_next;
         starve_cnt_reg <= starve_cnt_next;
         pipe_stall_reg <= pipe_stall_next;
         err_reg        <= err_next;
         pending_reg    <= pending_next;
         w_enb_reg      <= w_enb_next;
         rd_reg         <= rd_next;
         w_data_reg     <= w_data_next;
      end
   end

   assign pipe_stall = pipe_stall_reg;
   assign err        = err_reg;
   assign w_enb      = w_enb_reg;
   assign rd         = rd_reg;
   assign w_data     = w_data_reg;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
//
// Drives directed scenarios followed by randomized traffic into
// wb_port_arbiter and compares every cycle against a queue-based model of the
// writeback rules (FIFO as a queue, scoreboard as a bit array, starvation as
// an integer count).
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;

   localparam int XLEN       = 32;
   localparam int DEPTH      = 4;
   localparam int STARVE_MAX = 8;

   logic            clk;
   logic            rst;
   logic            alu_valid;
   logic [4:0]      alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            lu_valid;
   logic            lu_ready;
   logic [4:0]      lu_rd;
   logic [XLEN-1:0] lu_data;
   logic            issue_valid;
   logic [4:0]      issue_rd;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic            hazard;
   logic            pipe_stall;
   logic            err;
   logic            w_enb;
   logic [4:0]      rd;
   logic [XLEN-1:0] w_data;

   wb_port_arbiter #(
      .XLEN       (XLEN),
      .DEPTH      (DEPTH),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .alu_valid   (alu_valid),
      .alu_rd      (alu_rd),
      .alu_data    (alu_data),
      .lu_valid    (lu_valid),
      .lu_ready    (lu_ready),
      .lu_rd       (lu_rd),
      .lu_data     (lu_data),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .rs1         (rs1),
      .rs2         (rs2),
      .hazard      (hazard),
      .pipe_stall  (pipe_stall),
      .err         (err),
      .w_enb       (w_enb),
      .rd          (rd),
      .w_data      (w_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------
   // Reference model state
   // ---------------------------------------------------------------------
   typedef struct {
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } ent_t;

   ent_t            m_q[$];
   bit   [31:0]     m_pend;
   int              m_starve;
   bit              m_stall;
   bit              m_err;
   bit              m_wenb;
   logic [4:0]      m_rd;
   logic [XLEN-1:0] m_wdata;

   int total;
   int bad;

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_regs();
      check_value("w_enb", 64'(w_enb), 64'(m_wenb));
      check_value("rd", 64'(rd), 64'(m_rd));
      check_value("w_data", 64'(w_data), 64'(m_wdata));
      check_value("pipe_stall", 64'(pipe_stall), 64'(m_stall));
      check_value("err", 64'(err), 64'(m_err));
   endtask

   // Asynchronous reset applied between clock edges; entered and left at posedge+1.
   task automatic do_reset();
      alu_valid   = 1'b0;
      lu_valid    = 1'b0;
      issue_valid = 1'b0;
      rs1         = 5'd5;
      rs2         = 5'd0;
      rst         = 1'b1;
      #1;
      m_q.delete();
      m_pend   = '0;
      m_starve = 0;
      m_stall  = 1'b0;
      m_err    = 1'b0;
      m_wenb   = 1'b0;
      m_rd     = '0;
      m_wdata  = '0;
      check_regs();
      check_value("rst_lu_ready", 64'(lu_ready), 64'(1));
      check_value("rst_hazard", 64'(hazard), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      $display("reset applied");
   endtask

   // One clock cycle: apply inputs, check comb outputs, advance model, check regs.
   task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
                       input logic iv, input logic [4:0] ird,
                       input logic [4:0] r1, input logic [4:0] r2);
      bit         ne;
      bit         do_push;
      bit         from_fifo;
      bit         from_alu;
      logic [4:0] wr;
      logic [31:0] wd;
      ent_t       e;
      alu_valid   = av;
      alu_rd      = ard;
      alu_data    = adata;
      lu_valid    = lv;
      lu_rd       = lrd;
      lu_data     = ldata;
      issue_valid = iv;
      issue_rd    = ird;
      rs1         = r1;
      rs2         = r2;
      #1;
      check_value("lu_ready", 64'(lu_ready), 64'(m_q.size() < DEPTH));
      check_value("hazard", 64'(hazard), 64'(m_pend[r1] | m_pend[r2]));

      ne        = (m_q.size() != 0);
      do_push   = lv && (m_q.size() < DEPTH);
      from_fifo = ne && (m_stall || !av);
      from_alu  = !from_fifo && av;
      if (m_stall && ne && av) m_err = 1'b1;

      if (from_alu && ne) begin
         if (m_starve + 1 == STARVE_MAX) begin
            m_stall  = 1'b1;
            m_starve = 0;
         end else begin
            m_starve = m_starve + 1;
            m_stall  = 1'b0;
         end
      end else begin
         m_starve = 0;
         m_stall  = 1'b0;
      end

      wr = 5'd0;
      wd = '0;
      if (from_fifo) begin
         e  = m_q.pop_front();
         wr = e.rd;
         wd = e.data;
         m_pend[e.rd] = 1'b0;
      end else if (from_alu) begin
         wr = ard;
         wd = adata;
      end
      if (wr != 5'd0) begin
         m_wenb  = 1'b1;
         m_rd    = wr;
         m_wdata = wd;
      end else begin
         m_wenb = 1'b0;
      end
      if (iv && ird != 5'd0) m_pend[ird] = 1'b1;
      if (do_push) m_q.push_back('{rd: lrd, data: ldata});

      @(posedge clk);
      #1;
      check_regs();
      if (w_enb) $display("write rd=%0d data=%h", rd, w_data);
   endtask

   task automatic idle(input int n, input logic [4:0] r1);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, r1, 0);
   endtask

   // ALU busy every cycle while the FIFO is filled; optionally ignores pipe_stall.
   task automatic starve_run(input bit ignore_stall, input logic [4:0] base);
      logic av;
      for (int i = 0; i < 14; i++) begin
         av = (ignore_stall || !m_stall) ? 1'b1 : 1'b0;
         step(av, 5'd1, 32'hA000_0000 + 32'(i),
              (i < 4) ? 1'b1 : 1'b0, base + 5'(i), 32'hB000_0000 + 32'(i),
              0, 0, 0, 0);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst = 1'b0;
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      lu_valid = 0; lu_rd = 0; lu_data = 0;
      issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
      @(posedge clk);
      #1;
      do_reset();

      // Single ALU write into an idle FIFO.
      step(1, 5'd3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
      idle(1, 0);

      // Scoreboard: issue r7, result arrives later through the FIFO.
      step(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 0);
      idle(2, 5'd7);
      step(0, 0, 0, 1, 5'd7, 32'h1234, 0, 0, 5'd7, 0);
      idle(3, 5'd7);

      // x0 destinations from both sources are never written.
      step(1, 5'd0, 32'h5555, 1, 5'd0, 32'h6666, 0, 0, 0, 0);
      idle(2, 0);

      // Starvation with a well-behaved upstream, then with one that ignores the stall.
      starve_run(0, 5'd8);
      idle(5, 0);
      starve_run(1, 5'd16);
      idle(5, 0);

      // Reset while entries are queued and r5 is pending.
      step(1, 5'd2, 32'h1, 0, 0, 0, 1, 5'd5, 5'd5, 0);
      for (int i = 0; i < 3; i++)
         step(1, 5'd2, 32'h2, 1, 5'd5, 32'hC000_0000 + 32'(i), 0, 0, 5'd5, 0);
      do_reset();
      idle(4, 5'd5);

      // Randomized traffic in phases of different ALU/LU pressure.
      for (int ph = 0; ph < 5; ph++) begin
         int alu_pct;
         int lu_pct;
         bit violate;
         alu_pct = (ph == 0) ? 90 : (ph == 1) ? 50 : (ph == 2) ? 15 : 85;
         lu_pct  = (ph == 2) ? 30 : 70;
         violate = (ph == 4);
         for (int c = 0; c < 120; c++) begin
            logic av;
            av = ($urandom_range(0, 99) < alu_pct) ? 1'b1 : 1'b0;
            if (m_stall && !(violate && $urandom_range(0, 1) == 1)) av = 1'b0;
            step(av, 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 99) < lu_pct) ? 1'b1 : 1'b0,
                 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         end
         if (ph == 1) do_reset();
      end
      idle(6, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
